// File: rtl/wb_dsp_wb_master_pkg.sv
// Shared definitions for the DSP Wishbone master.
//  - wb_state_e : FSM state encodings (idle, bus cycle in flight, retry backoff)
//  - WbCtiClassic / WbBteLinear : constant cycle-type and burst-type codes
//  - cnt_width() : width of a counter that must hold 0..max_val (at least 1 bit)
package wb_dsp_wb_master_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBus     = 2'd1,
    StBackoff = 2'd2
  } wb_state_e;

  localparam logic [2:0] WbCtiClassic = 3'b000;
  localparam logic [1:0] WbBteLinear  = 2'b00;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_dsp_master_timer.sv
// Counters for the DSP Wishbone master.
//  Backoff: loadable down-counter. bo_load loads RETRY_DELAY, bo_run decrements;
//  bo_done is high in the last backoff cycle so the reissue edge ends a gap of
//  exactly RETRY_DELAY idle cycles.
//  Watchdog (only with WB_DSP_MASTER_TIMEOUT_EN defined): clearable up-counter;
//  wd_limit is high in the TIMEOUT-th consecutive cycle without a termination.
//  Without the macro wd_limit is tied low and no watchdog state exists.
// Ports:
//  wb_clk, wb_rst       clock, asynchronous active-high reset
//  bo_load, bo_run      backoff load / decrement enables
//  bo_done              backoff expires at the next edge
//  wd_clr, wd_inc       watchdog clear / increment enables
//  wd_limit             watchdog reaches TIMEOUT at the next edge
module wb_dsp_master_timer
  import wb_dsp_wb_master_pkg::*;
#(
  parameter int unsigned RETRY_DELAY = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic wb_clk,
  input  logic wb_rst,
  input  logic bo_load,
  input  logic bo_run,
  output logic bo_done,
  input  logic wd_clr,
  input  logic wd_inc,
  output logic wd_limit
);

  localparam int unsigned BoW = cnt_width(RETRY_DELAY);

  logic [BoW-1:0] bo_cnt_q;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      bo_cnt_q <= '0;
    end else if (bo_load) begin
      bo_cnt_q <= BoW'(RETRY_DELAY);
    end else if (bo_run && (bo_cnt_q != '0)) begin
      bo_cnt_q <= bo_cnt_q - BoW'(1);
    end
  end

  assign bo_done = (bo_cnt_q <= BoW'(1));

`ifdef WB_DSP_MASTER_TIMEOUT_EN
  localparam int unsigned WdW = cnt_width(TIMEOUT);

  logic [WdW-1:0] wd_cnt_q;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wd_cnt_q <= '0;
    end else if (wd_clr) begin
      wd_cnt_q <= '0;
    end else if (wd_inc) begin
      wd_cnt_q <= wd_cnt_q + WdW'(1);
    end
  end

  // Compare one below the limit so the abort lands on the edge that would
  // make the count equal TIMEOUT, i.e. after exactly TIMEOUT strobe cycles.
  assign wd_limit = (wd_cnt_q == WdW'(TIMEOUT - 1));
`else
  logic unused_wd;
  assign unused_wd = wd_clr ^ wd_inc ^ (^TIMEOUT);
  assign wd_limit  = 1'b0;
`endif

endmodule

// File: rtl/wb_dsp_wb_master.sv
// Wishbone B3 classic-cycle initiator for the DSP engine.
//  Accepts one single-word command when idle, runs it on the bus, and returns a
//  one-cycle response. Slave err, or rty beyond MAX_RETRY, reports rsp_err.
//  A rty backs off RETRY_DELAY idle cycles, then reissues the latched command.
//  Optional watchdog (define WB_DSP_MASTER_TIMEOUT_EN) aborts a cycle after
//  TIMEOUT strobe cycles with no termination.
// Ports:
//  wb_clk, wb_rst                    clock, asynchronous active-high reset
//  cmd_valid/cmd_ready               command handshake (ready only when idle)
//  cmd_we, cmd_adr, cmd_dat, cmd_sel command fields
//  rsp_valid, rsp_dat, rsp_err       one-cycle response, read data, error flag
//  busy                              FSM not idle
//  wb_*_o / wb_*_i                   Wishbone master interface
module wb_dsp_wb_master
  import wb_dsp_wb_master_pkg::*;
#(
  parameter int unsigned dw          = 32,
  parameter int unsigned aw          = 32,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned RETRY_DELAY = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [aw-1:0] cmd_adr,
  input  logic [dw-1:0] cmd_dat,
  input  logic [3:0]    cmd_sel,
  output logic          rsp_valid,
  output logic [dw-1:0] rsp_dat,
  output logic          rsp_err,
  output logic          busy,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  localparam int unsigned RetryW = cnt_width(MAX_RETRY);

  wb_state_e       state_q, state_d;
  logic            cyc_q, cyc_d;
  logic [aw-1:0]   adr_q, adr_d;
  logic [dw-1:0]   dat_q, dat_d;
  logic [3:0]      sel_q, sel_d;
  logic            we_q, we_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [dw-1:0]   rsp_dat_q, rsp_dat_d;
  logic            rsp_err_q, rsp_err_d;

  logic bo_load, bo_run, bo_done;
  logic wd_clr, wd_inc, wd_limit;
  logic term, bus_fail;

  assign term   = wb_ack_i | wb_err_i | wb_rty_i;
  assign wd_inc = (state_q == StBus) & ~term;

  wb_dsp_master_timer #(
    .RETRY_DELAY (RETRY_DELAY),
    .TIMEOUT     (TIMEOUT)
  ) u_timer (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .bo_load  (bo_load),
    .bo_run   (bo_run),
    .bo_done  (bo_done),
    .wd_clr   (wd_clr),
    .wd_inc   (wd_inc),
    .wd_limit (wd_limit)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    retry_d     = retry_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    bo_load     = 1'b0;
    bo_run      = 1'b0;
    wd_clr      = 1'b0;
    bus_fail    = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          we_d    = cmd_we;
          cyc_d   = 1'b1;
          retry_d = '0;
          wd_clr  = 1'b1;
          state_d = StBus;
        end
      end
      StBus: begin
        // err > ack > rty; the watchdog only fires when no term is present.
        if (wb_err_i) begin
          bus_fail = 1'b1;
        end else if (wb_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (!we_q) begin
            rsp_dat_d = wb_dat_i;
          end
          state_d = StIdle;
        end else if (wb_rty_i) begin
          if (retry_q < RetryW'(MAX_RETRY)) begin
            cyc_d   = 1'b0;
            retry_d = retry_q + RetryW'(1);
            bo_load = 1'b1;
            state_d = StBackoff;
          end else begin
            bus_fail = 1'b1;
          end
        end else if (wd_limit) begin
          bus_fail = 1'b1;
        end
      end
      StBackoff: begin
        bo_run = 1'b1;
        if (bo_done) begin
          cyc_d   = 1'b1;
          wd_clr  = 1'b1;
          state_d = StBus;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = StIdle;
      end
    endcase

    if (bus_fail) begin
      cyc_d       = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      state_d     = StIdle;
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      retry_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      retry_q     <= retry_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_cti_o  = WbCtiClassic;
  assign wb_bte_o  = WbBteLinear;

endmodule
